// File: rtl/rsa_pkg.sv
// Shared constants for the RSA datapath: operand width, FSM states and a
// saturating increment used by the latency counter.
package rsa_pkg;
  localparam int OPERAND_WIDTH = 1025;
  localparam int LAT_W         = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/adder_arbiter_if.sv
// Control/data bundle between the arbiter and the shared multi-precision adder.
interface adder_arbiter_if #(parameter int WIDTH = rsa_pkg::OPERAND_WIDTH);
  logic             start;
  logic             subtract;
  logic             shift;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   result;
  logic             done;

  modport master (output start, subtract, shift, in_a, in_b, input result, done);
  modport slave  (input start, subtract, shift, in_a, in_b, output result, done);
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the
// requester that was not served last.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb begin
    grant = valid;
    if (&valid) grant = last_grant ? 2'b01 : 2'b10;
  end
endmodule

// File: rtl/adder_arbiter.sv
// Shares one multi-precision adder between two requesters; one operation in
// flight at a time, result and latency held until the next completion.
module adder_arbiter
  import rsa_pkg::*;
#(
  parameter int WIDTH = OPERAND_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  output logic             req0_ready,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             req1_ready,
  output logic             req1_done,
  output logic [WIDTH:0]   rsp_result,
  output logic [15:0]      lat_cycles,
  output logic             add_start,
  output logic             add_subtract,
  output logic             add_shift,
  output logic [WIDTH-1:0] add_in_a,
  output logic [WIDTH-1:0] add_in_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);
  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, gidx_q, last_grant_q;
  logic             start_q, shift_q, done0_q, done1_q;
  logic [WIDTH:0]   rsp_q;
  logic [15:0]      cnt_q, lat_q, cnt_d;
  logic [1:0]       grant, accept;

  rr_arbiter2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // ready is only offered while idle and out of reset
  assign accept = (state_q == IDLE && resetn) ? grant : 2'b00;
  assign cnt_d  = sat_inc(cnt_q);

  assign req0_ready   = accept[0];
  assign req1_ready   = accept[1];
  assign req0_done    = done0_q;
  assign req1_done    = done1_q;
  assign rsp_result   = rsp_q;
  assign lat_cycles   = lat_q;
  assign add_start    = start_q;
  assign add_shift    = shift_q;
  assign add_subtract = sub_q;
  assign add_in_a     = a_q;
  assign add_in_b     = b_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      sub_q        <= 1'b0;
      gidx_q       <= 1'b0;
      last_grant_q <= 1'b1;
      start_q      <= 1'b0;
      shift_q      <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      rsp_q        <= '0;
      cnt_q        <= '0;
      lat_q        <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: if (|accept) begin
          gidx_q  <= accept[1];
          a_q     <= accept[1] ? req1_a   : req0_a;
          b_q     <= accept[1] ? req1_b   : req0_b;
          sub_q   <= accept[1] ? req1_sub : req0_sub;
          start_q <= 1'b1;
          cnt_q   <= 16'd1;
          state_q <= START;
        end
        START: begin
          start_q <= 1'b0;
          shift_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (add_done) begin
            rsp_q   <= add_result;
            lat_q   <= cnt_d;
            shift_q <= 1'b0;
            sub_q   <= 1'b0;
            done0_q <= ~gidx_q;
            done1_q <= gidx_q;
            state_q <= RESP;
          end
        end
        RESP: begin
          last_grant_q <= gidx_q;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench: transaction-timeline model of the arbiter, an adder stub with
// configurable completion delay, directed scenarios plus random traffic.
module tb_adder_arbiter;
  import rsa_pkg::*;
  localparam int W = OPERAND_WIDTH;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic         req0_valid, req1_valid, req0_sub, req1_sub;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready, req0_done, req1_done;
  logic [W:0]   rsp_result;
  logic [15:0]  lat_cycles;

  adder_arbiter_if #(.WIDTH(W)) aif ();

  adder_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req0_ready(req0_ready), .req0_done(req0_done),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .req1_ready(req1_ready), .req1_done(req1_done),
    .rsp_result(rsp_result), .lat_cycles(lat_cycles),
    .add_start(aif.start), .add_subtract(aif.subtract), .add_shift(aif.shift),
    .add_in_a(aif.in_a), .add_in_b(aif.in_b),
    .add_result(aif.result), .add_done(aif.done)
  );

  int checks = 0, failures = 0, cyc = 0;

  // model state
  bit         busy;
  int         t_acc, cur_d, o_g, last_g;
  logic [W-1:0] o_a, o_b;
  bit         o_sub;
  logic [W:0] exp_rsp;
  logic [15:0] exp_lat;
  // stimulus control
  bit         pv[2], ps[2];
  logic [W-1:0] pa[2], pb[2];
  bit         gen_en;
  int         rate, fixed_d, done_noise;
  // observed from the DUT
  int         obs_grant[$], obs_acc[$], obs_done[$];

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
    case ($urandom_range(3))
      0: v = W'($urandom_range(15));
      1: v = '1;
      default: ;
    endcase
    return v;
  endfunction

  task automatic chkw(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (low 64 bits) cycle %0d", name, act[63:0], exp[63:0], cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    chkw(name, (W+1)'(act), (W+1)'(exp));
  endtask

  task automatic model_reset();
    busy = 0; exp_rsp = '0; exp_lat = '0; last_g = 1;
    pv[0] = 0; pv[1] = 0;
  endtask

  // called at a falling edge: asserts reset, checks outputs are forced low, releases
  task automatic do_reset();
    resetn = 1'b0;
    if (done_noise == 2) aif.done = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk1("rst_start", aif.start, 1'b0);
    chk1("rst_shift", aif.shift, 1'b0);
    chk1("rst_subtract", aif.subtract, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk1("rst_done0", req0_done, 1'b0);
    chk1("rst_done1", req1_done, 1'b0);
    chkw("rst_rsp", rsp_result, '0);
    chkw("rst_lat", (W+1)'(lat_cycles), '0);
    chkw("rst_in_a", {1'b0, aif.in_a}, '0);
    chkw("rst_in_b", {1'b0, aif.in_b}, '0);
    @(posedge clk); cyc++;
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic step();
    int rel, g;
    bit in_op, resp_now, elig;
    rel = busy ? cyc - t_acc : -1;
    in_op    = busy && rel >= 1 && rel <= 1 + cur_d;
    resp_now = busy && rel == 2 + cur_d;
    chk1("add_start", aif.start, busy && rel == 1);
    chk1("add_shift", aif.shift, busy && rel >= 2 && rel <= 1 + cur_d);
    if (in_op) begin
      chk1("add_subtract", aif.subtract, o_sub);
      chkw("add_in_a", {1'b0, aif.in_a}, {1'b0, o_a});
      chkw("add_in_b", {1'b0, aif.in_b}, {1'b0, o_b});
    end
    chk1("req0_done", req0_done, resp_now && o_g == 0);
    chk1("req1_done", req1_done, resp_now && o_g == 1);
    if (req0_done) obs_done.push_back(0);
    if (req1_done) obs_done.push_back(1);
    if (resp_now) begin
      exp_rsp = o_sub ? ({1'b0, o_a} - {1'b0, o_b}) : ({1'b0, o_a} + {1'b0, o_b});
      exp_lat = 16'(1 + cur_d);
    end
    chkw("rsp_result", rsp_result, exp_rsp);
    chkw("lat_cycles", (W+1)'(lat_cycles), (W+1)'(exp_lat));
    // adder stub: completes on RUN cycle number cur_d, otherwise idle/noise
    if (busy && rel == 1 + cur_d) begin
      aif.done = 1'b1;
      aif.result = aif.subtract ? ({1'b0, aif.in_a} - {1'b0, aif.in_b})
                                : ({1'b0, aif.in_a} + {1'b0, aif.in_b});
    end else if (busy && rel >= 2 && rel <= cur_d) begin
      aif.done = 1'b0;
      aif.result = {1'b0, rnd_w()};
    end else begin
      aif.done = (done_noise == 2) ? 1'b1 : (done_noise == 1) ? 1'($urandom_range(1)) : 1'b0;
      aif.result = {1'b0, rnd_w()};
    end
    for (int i = 0; i < 2; i++)
      if (!pv[i] && gen_en && $urandom_range(99) < rate) begin
        pv[i] = 1; pa[i] = rnd_w(); pb[i] = rnd_w(); ps[i] = 1'($urandom_range(1));
      end
    req0_valid = pv[0]; req0_a = pv[0] ? pa[0] : rnd_w(); req0_b = pv[0] ? pb[0] : rnd_w();
    req0_sub   = pv[0] ? ps[0] : 1'($urandom_range(1));
    req1_valid = pv[1]; req1_a = pv[1] ? pa[1] : rnd_w(); req1_b = pv[1] ? pb[1] : rnd_w();
    req1_sub   = pv[1] ? ps[1] : 1'($urandom_range(1));
    #1;
    elig = !busy;
    g = -1;
    if (elig && (pv[0] || pv[1])) g = (pv[0] && pv[1]) ? (last_g == 1 ? 0 : 1) : (pv[0] ? 0 : 1);
    chk1("req0_ready", req0_ready, g == 0);
    chk1("req1_ready", req1_ready, g == 1);
    if (req0_ready) begin obs_grant.push_back(0); obs_acc.push_back(cyc); end
    if (req1_ready) begin obs_grant.push_back(1); obs_acc.push_back(cyc); end
    if (resp_now) busy = 0;
    if (g >= 0) begin
      busy = 1; t_acc = cyc; o_g = g; last_g = g;
      o_a = pa[g]; o_b = pb[g]; o_sub = ps[g]; pv[g] = 0;
      cur_d = (fixed_d > 0) ? fixed_d : $urandom_range(1, 4);
    end
    @(posedge clk); cyc++;
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pend(input int i, input int a, input int b, input bit s);
    pv[i] = 1; pa[i] = W'(a); pb[i] = W'(b); ps[i] = s;
  endtask

  initial begin
    int s, sd, nd;
    logic [W:0] lit;
    req0_valid = 0; req1_valid = 0; req0_sub = 0; req1_sub = 0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    aif.done = 1'b0; aif.result = '0;
    gen_en = 0; rate = 0; fixed_d = 3; done_noise = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    // req0 1+1, adder done on 3rd RUN cycle
    sd = obs_done.size();
    pend(0, 1, 1, 0);
    steps(8);
    chkw("r031_rsp", rsp_result, (W+1)'(2));
    chkw("r031_lat", (W+1)'(lat_cycles), (W+1)'(4));
    chkw("r031_ndone", (W+1)'(obs_done.size() - sd), (W+1)'(1));
    chkw("r031_done_id", (W+1)'(obs_done[sd]), (W+1)'(0));

    // req1 1-1 with subtract
    pend(1, 1, 1, 1);
    steps(8);
    chkw("r032_rsp", rsp_result, '0);
    chkw("r032_done_id", (W+1)'(obs_done[obs_done.size()-1]), (W+1)'(1));

    // both valid right after reset
    do_reset();
    s = obs_grant.size(); sd = obs_done.size();
    pend(0, 5, 7, 0); pend(1, 9, 4, 1);
    steps(14);
    chkw("r033_ngrant", (W+1)'(obs_grant.size() - s), (W+1)'(2));
    if (obs_grant.size() >= s + 2) begin
      chkw("r033_first", (W+1)'(obs_grant[s]), (W+1)'(0));
      chkw("r033_second", (W+1)'(obs_grant[s+1]), (W+1)'(1));
    end
    if (obs_done.size() >= sd + 2) begin
      chkw("r033_done0", (W+1)'(obs_done[sd]), (W+1)'(0));
      chkw("r033_done1", (W+1)'(obs_done[sd+1]), (W+1)'(1));
    end
    chkw("r033_rsp", rsp_result, (W+1)'(5));

    // both held valid for four operations, adder delay 2
    s = obs_grant.size();
    fixed_d = 2; gen_en = 1; rate = 100;
    steps(18);
    gen_en = 0;
    steps(16);
    if (obs_grant.size() < s + 4) begin
      checks++; failures++;
      $display("FAIL r034_count: got %0d grants expected at least 4", obs_grant.size() - s);
    end else begin
      for (int i = 0; i < 4; i++)
        chkw("r034_order", (W+1)'(obs_grant[s+i]), (W+1)'(i % 2));
      for (int i = 1; i < 4; i++)
        chkw("r034_spacing", (W+1)'(obs_acc[s+i] - obs_acc[s+i-1]), (W+1)'(5));
    end

    // reset during RUN, then add_done held high while idle
    fixed_d = 4;
    pend(0, 11, 22, 0);
    steps(3);
    done_noise = 2;
    nd = obs_done.size();
    do_reset();
    steps(5);
    chkw("r035_nodone", (W+1)'(obs_done.size()), (W+1)'(nd));

    // add_done high in IDLE and START must not complete early
    fixed_d = 3;
    pend(1, 3, 5, 1);
    steps(8);
    chkw("r036_lat", (W+1)'(lat_cycles), (W+1)'(4));
    lit = '1; lit = lit - 1'b1;
    chkw("r036_rsp", rsp_result, lit);

    // random traffic with noise and a mid-run reset
    done_noise = 1; fixed_d = 0; gen_en = 1; rate = 40;
    steps(200);
    do_reset();
    steps(200);
    gen_en = 0;
    steps(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
